// File: rtl/brp_pkg.sv
// Shared types for the branch predictor: counter states, control opcodes, BTB entry.
package brp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam logic [6:0] B_TYPE = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  // Tag is held zero-extended to the widest possible tag so one struct serves any IDX_W/TAG_W.
  typedef struct packed {
    logic        vld;
    logic [29:0] tag;
    logic [31:0] target;
    ctr_e        ctr;
  } btb_entry_t;

  function automatic logic is_ctrl_op(input logic [6:0] opc);
    return (opc == B_TYPE) || (opc == JAL) || (opc == JALR);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side prediction and EX-side resolution/redirect signals of the branch predictor.
interface branch_predictor_if;
  logic [31:0] i_fetch_pc;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        i_ex_vld;
  logic        i_ex_is_ctrl;
  logic [31:0] i_ex_pc;
  logic        i_ex_taken;
  logic [31:0] i_ex_target;
  logic        i_ex_pred_taken;
  logic [31:0] i_ex_pred_target;
  logic        o_flush;
  logic [31:0] o_redirect_pc;

  modport slave (
    input  i_fetch_pc, i_ex_vld, i_ex_is_ctrl, i_ex_pc, i_ex_taken, i_ex_target,
           i_ex_pred_taken, i_ex_pred_target,
    output o_pred_taken, o_pred_target, o_flush, o_redirect_pc
  );

  modport master (
    output i_fetch_pc, i_ex_vld, i_ex_is_ctrl, i_ex_pc, i_ex_taken, i_ex_target,
           i_ex_pred_taken, i_ex_pred_target,
    input  o_pred_taken, o_pred_target, o_flush, o_redirect_pc
  );
endinterface

// File: rtl/brp_sat_counter.sv
// 2-bit saturating counter next-state: inc=1 counts toward ST, inc=0 toward SNT.
module brp_sat_counter
  import brp_pkg::*;
(
  input  ctr_e ctr,
  input  logic inc,
  output ctr_e nxt
);
  always_comb begin
    nxt = ctr;
    unique case (ctr)
      SNT: if (inc) nxt = WNT;
      WNT: if (inc) nxt = WT; else nxt = SNT;
      WT:  if (inc) nxt = ST; else nxt = WNT;
      ST:  if (!inc) nxt = WT;
      default: nxt = ctr;
    endcase
  end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, trained at EX, registered flush/redirect on mispredict.
// Define BRP_STATS_EN to add update/mispredict statistics counters.
module branch_predictor
  import brp_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  branch_predictor_if.slave   bus
`ifdef BRP_STATS_EN
  ,
  output logic [31:0]         o_stat_ctrl,
  output logic [31:0]         o_stat_mispred
`endif
);
  localparam int DEPTH = 1 << IDX_W;

  btb_entry_t       btb [DEPTH];
  logic [IDX_W-1:0] f_idx, e_idx;
  logic [29:0]      f_tag, e_tag;
  btb_entry_t       f_ent, e_ent;
  logic             f_hit, e_hit, upd, mis;
  ctr_e             ctr_nxt;

  assign f_idx = bus.i_fetch_pc[IDX_W+1:2];
  assign f_tag = 30'(bus.i_fetch_pc[IDX_W+TAG_W+1:IDX_W+2]);
  assign e_idx = bus.i_ex_pc[IDX_W+1:2];
  assign e_tag = 30'(bus.i_ex_pc[IDX_W+TAG_W+1:IDX_W+2]);

  // Reads see the table before this cycle's update lands.
  assign f_ent = btb[f_idx];
  assign f_hit = f_ent.vld && (f_ent.tag == f_tag);
  assign bus.o_pred_taken  = f_hit && f_ent.ctr[1];
  assign bus.o_pred_target = bus.o_pred_taken ? f_ent.target : 32'h0;

  assign e_ent = btb[e_idx];
  assign e_hit = e_ent.vld && (e_ent.tag == e_tag);
  assign upd   = bus.i_ex_vld && bus.i_ex_is_ctrl;
  assign mis   = upd && ((bus.i_ex_taken != bus.i_ex_pred_taken) ||
                         (bus.i_ex_taken && bus.i_ex_pred_taken &&
                          (bus.i_ex_target != bus.i_ex_pred_target)));

  brp_sat_counter u_ctr (
    .ctr (e_ent.ctr),
    .inc (bus.i_ex_taken),
    .nxt (ctr_nxt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        btb[i] <= '{vld: 1'b0, tag: '0, target: '0, ctr: WNT};
    end else if (upd) begin
      if (e_hit) begin
        btb[e_idx].ctr <= ctr_nxt;
        if (bus.i_ex_taken) btb[e_idx].target <= bus.i_ex_target;
      end else if (bus.i_ex_taken) begin
        btb[e_idx] <= '{vld: 1'b1, tag: e_tag, target: bus.i_ex_target, ctr: WT};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_flush       <= 1'b0;
      bus.o_redirect_pc <= 32'h0;
    end else begin
      bus.o_flush <= mis;
      if (mis)
        bus.o_redirect_pc <= bus.i_ex_taken ? bus.i_ex_target : bus.i_ex_pc + 32'd4;
    end
  end

`ifdef BRP_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stat_ctrl    <= 32'h0;
      o_stat_mispred <= 32'h0;
    end else begin
      if (upd) o_stat_ctrl    <= o_stat_ctrl + 32'd1;
      if (mis) o_stat_mispred <= o_stat_mispred + 32'd1;
    end
  end
`endif

  // PC bits outside the index/tag/offset window are don't-care by design.
  logic unused;
  assign unused = ^{bus.i_fetch_pc, bus.i_ex_pc};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;
  logic i_clk = 1'b0;
  logic i_rst_n;
  always #5 i_clk = ~i_clk;

  branch_predictor_if bus();

`ifdef BRP_STATS_EN
  logic [31:0] o_stat_ctrl, o_stat_mispred;
`endif

  branch_predictor #(.IDX_W(6), .TAG_W(8)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
`ifdef BRP_STATS_EN
    ,
    .o_stat_ctrl    (o_stat_ctrl),
    .o_stat_mispred (o_stat_mispred)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic ex(input logic [31:0] pc, input logic ctrl, input logic tk,
                    input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    bus.i_ex_vld         = 1'b1;
    bus.i_ex_is_ctrl     = ctrl;
    bus.i_ex_pc          = pc;
    bus.i_ex_taken       = tk;
    bus.i_ex_target      = tgt;
    bus.i_ex_pred_taken  = ptk;
    bus.i_ex_pred_target = ptgt;
  endtask

  task automatic idle();
    bus.i_ex_vld     = 1'b0;
    bus.i_ex_is_ctrl = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt);
    bus.i_fetch_pc = pc;
    #1;
    chk({tag, "_tk"}, 32'(bus.o_pred_taken), 32'(tk));
    chk({tag, "_tgt"}, bus.o_pred_target, tgt);
  endtask

  task automatic chkf(input string tag, input logic fl, input logic [31:0] rd);
    chk({tag, "_fl"}, 32'(bus.o_flush), 32'(fl));
    chk({tag, "_rd"}, bus.o_redirect_pc, rd);
  endtask

  initial begin
    i_rst_n = 1'b1;
    bus.i_fetch_pc = 32'h0;
    idle();
    bus.i_ex_pc = 32'h0;
    bus.i_ex_taken = 1'b0;
    bus.i_ex_target = 32'h0;
    bus.i_ex_pred_taken = 1'b0;
    bus.i_ex_pred_target = 32'h0;
    #1 i_rst_n = 1'b0;

    fetch("rst_pred", 32'h100, 1'b0, 32'h0);
    chkf("rst", 1'b0, 32'h0);
    step(); step();
    i_rst_n = 1'b1;
    step();
    chkf("post_rst", 1'b0, 32'h0);

    // Train 0x100: miss-taken allocates WT.
    ex(32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    step();
    chkf("train", 1'b1, 32'h200);
    idle();
    fetch("train_pred", 32'h100, 1'b1, 32'h200);
    step();
    chkf("train_hold", 1'b0, 32'h200);

    // Three correct taken resolutions saturate at ST.
    for (int i = 0; i < 3; i++) begin
      ex(32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200);
      step();
      chk("sat_nofl", 32'(bus.o_flush), 32'h0);
    end

    // Two back-to-back not-taken: ST->WT (still taken) then WNT.
    ex(32'h100, 1'b1, 1'b0, 32'h200, 1'b1, 32'h200);
    step();
    chkf("nt1", 1'b1, 32'h104);
    fetch("nt1_pred", 32'h100, 1'b1, 32'h200);
    step();
    chkf("nt2", 1'b1, 32'h104);
    idle();
    fetch("nt2_pred", 32'h100, 1'b0, 32'h0);

    // Retrain to WT, then alias 0x200 evicts it.
    ex(32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    step();
    chkf("retrain", 1'b1, 32'h200);
    idle();
    fetch("retrain_pred", 32'h100, 1'b1, 32'h200);
    ex(32'h200, 1'b1, 1'b1, 32'h600, 1'b0, 32'h0);
    step();
    chkf("alias", 1'b1, 32'h600);
    idle();
    fetch("alias_new", 32'h200, 1'b1, 32'h600);
    fetch("alias_old", 32'h100, 1'b0, 32'h0);

    // JALR target change at 0x300.
    ex(32'h300, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0);
    step();
    chkf("jalr_alloc", 1'b1, 32'h400);
    ex(32'h300, 1'b1, 1'b1, 32'h500, 1'b1, 32'h400);
    step();
    chkf("jalr_tgt", 1'b1, 32'h500);
    idle();
    fetch("jalr_pred", 32'h300, 1'b1, 32'h500);

    // Non-control and invalid EX never update or flush.
    ex(32'h300, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0);
    step();
    chkf("nonctrl", 1'b0, 32'h500);
    idle();
    fetch("nonctrl_pred", 32'h300, 1'b1, 32'h500);
    ex(32'h300, 1'b1, 1'b1, 32'h700, 1'b0, 32'h0);
    bus.i_ex_vld = 1'b0;
    step();
    chk("novld_fl", 32'(bus.o_flush), 32'h0);
    idle();
    fetch("novld_pred", 32'h300, 1'b1, 32'h500);

    // Not-taken redirect wraps past 2^32.
    ex(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10);
    step();
    chkf("wrap", 1'b1, 32'h0);
    idle();

    // Read-before-write on the same index.
    ex(32'h300, 1'b1, 1'b1, 32'h800, 1'b1, 32'h500);
    fetch("rbw_old", 32'h300, 1'b1, 32'h500);
    step();
    chkf("rbw", 1'b1, 32'h800);
    idle();
    fetch("rbw_new", 32'h300, 1'b1, 32'h800);

    // Reset right after a mispredict drops the flush and clears the table.
    ex(32'h300, 1'b1, 1'b1, 32'h900, 1'b1, 32'h800);
    step();
    chkf("pre_rst", 1'b1, 32'h900);
    idle();
    #1 i_rst_n = 1'b0;
    #1;
    chkf("mid_rst", 1'b0, 32'h0);
    fetch("mid_rst_pred", 32'h300, 1'b0, 32'h0);
    step();
    i_rst_n = 1'b1;
    step();
    chkf("after_rst", 1'b0, 32'h0);
    fetch("after_rst_pred", 32'h300, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Gives fetch a taken/target prediction every cycle.
- Is trained at execute by the resolved taken decision from the branch-resolution logic.
- Compares each prediction against the resolved outcome and issues a registered flush/redirect to the PC mux.

Parameters:
- IDX_W, 6, BTB index width; the table holds 2**IDX_W entries.
- TAG_W, 8, tag width stored per entry.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_fetch_pc  input  32  PC being fetched this cycle.
- o_pred_taken  output  1  predicted taken for i_fetch_pc (combinational).
- o_pred_target  output  32  predicted target; 0 when o_pred_taken=0.
- i_ex_vld  input  1  an instruction is resolving in EX this cycle.
- i_ex_is_ctrl  input  1  the EX instruction is B_type, JAL or JALR.
- i_ex_pc  input  32  PC of the EX instruction.
- i_ex_taken  input  1  resolved taken (pc_sel from branch resolution).
- i_ex_target  input  32  resolved target address.
- i_ex_pred_taken  input  1  prediction carried down the pipe with the instruction.
- i_ex_pred_target  input  32  predicted target carried down the pipe.
- o_flush  output  1  registered one-cycle pulse: a mispredict was detected.
- o_redirect_pc  output  32  correct next PC, valid while o_flush=1.

Behaviour:
- Address split: index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Entry fields: valid, tag, target[31:0], ctr[1:0].
- Reset (async, i_rst_n=0), including mid-operation:
  - all valid=0, all ctr=WNT(01), targets and tags=0;
  - o_flush=0, o_redirect_pc=0;
  - any pending redirect is dropped.
- Predict (combinational, same cycle):
  - hit = valid[index] and tag match;
  - o_pred_taken = hit and ctr[1];
  - o_pred_target = stored target when o_pred_taken, else 0.
- Update (clock edge, only when i_ex_vld and i_ex_is_ctrl):
  - Hit, taken: ctr saturates up (ST stays ST); target is overwritten with i_ex_target.
  - Hit, not taken: ctr saturates down (SNT stays SNT); target is unchanged.
  - Miss, taken: allocate/replace the entry with valid=1, new tag, target=i_ex_target, ctr=WT(10).
  - Miss, not taken: no change.
- Same-index read and write in one cycle: the prediction uses the pre-update contents (read-before-write).
- Mispredict detection (only when i_ex_vld and i_ex_is_ctrl):
  - mispredict when i_ex_taken != i_ex_pred_taken, or when both are 1 and i_ex_target != i_ex_pred_target.
- Redirect timing: the registered result appears the next cycle.
  - o_flush=1 for exactly one cycle.
  - o_redirect_pc = i_ex_target if i_ex_taken, else i_ex_pc+4 (wraps modulo 2^32).
- No mispredict (or i_ex_vld=0): o_flush=0 next cycle; o_redirect_pc holds its last value.
- Back-to-back mispredicts produce back-to-back flush pulses, each carrying its own redirect PC.
- Non-control instructions (i_ex_is_ctrl=0) never update the table or flush, regardless of the prediction fields.

Optional Feature:
- Macro: BRP_STATS_EN.
- Defined:
  - adds o_stat_ctrl[31:0], which counts updates;
  - adds o_stat_mispred[31:0], which counts mispredicts;
  - both reset to 0, increment at the update edge and wrap at 2^32.
- Undefined: ports and counters are absent; the remaining behaviour is identical.

Decomposition:
- Package brp_pkg holds:
  - 2-bit counter enum SNT=00, WNT=01, WT=10, ST=11;
  - opcode constants B_type, JAL, JALR;
  - a BTB entry struct typedef.
- One sub-module, brp_sat_counter: 2-bit saturating next-state logic with an inc/dec input.
  - Instantiated once, on the update path.

Test Plan:
- Reset, then fetch PC 0x100 -> o_pred_taken=0 and o_pred_target=0; release reset -> o_flush=0.
- Train the predictor at PC 0x100:
  - EX branch at 0x100, taken, target 0x200, pred 0 -> next cycle o_flush=1 with redirect 0x200;
  - fetch 0x100 afterwards -> pred taken, target 0x200.
- Saturation and untraining at PC 0x100:
  - Three more taken resolutions -> ctr=ST, no flushes.
  - Two not-taken resolutions -> o_flush pulses with redirect 0x104 each; ctr=WNT; fetch 0x100 predicts not taken.
- JALR target change: entry at 0x300 holds target 0x400; EX resolves taken to 0x500 with pred target 0x400 -> flush, redirect 0x500; fetch 0x300 then predicts 0x500.
- Aliasing and non-control instructions:
  - PC 0x100 and PC 0x100+(4<<IDX_W) share an index; the second allocates and evicts the first, after which 0x100 misses.
  - A non-control EX instruction with mismatched prediction fields gives no flush and no table change.
- Concurrency:
  - Assert i_rst_n=0 in the cycle after a mispredict -> o_flush drops immediately and the table clears.
  - Same-index predict and update in one cycle -> the prediction reflects the old entry.
